timer_ctrl: RTL and testbench



---
 rtl/timer_ctrl.sv | 148 ++++++++++++++
 tb/tb_timer_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - programmable one-shot/periodic timer around the up/down Counter datapath
// Optional macro TIMER_CTRL_PRESCALE_EN adds the prescale port and step divider.

module Counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] in,
   input  logic             up_down,
   input  logic             count_en,
   output logic [WIDTH-1:0] count,
   output logic             co
);

   always_ff @(posedge clk) begin
      if (!rst_n)
         count <= '0;
      else if (load)
         count <= in;
      else if (count_en)
         count <= up_down ? count + 1'b1 : count - 1'b1;
   end

   assign co = count_en && (up_down ? (count == {WIDTH{1'b1}}) : (count == '0));

endmodule

module timer_ctrl #(
   parameter int WIDTH     = 8,
   parameter int PRE_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 mode,
   input  logic                 dir,
   input  logic [WIDTH-1:0]     reload,
`ifdef TIMER_CTRL_PRESCALE_EN
   input  logic [PRE_WIDTH-1:0] prescale,
`endif
   output logic [WIDTH-1:0]     count,
   output logic                 busy,
   output logic                 tick
);

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;

   state_t           state, state_nx;
   logic             cfg_mode;
   logic             cfg_dir;
   logic [WIDTH-1:0] cfg_reload;
   logic             accept;
   logic             step;
   logic             at_term;
   logic             run_ok;
   logic             term_hit;
   logic             cnt_load;
   logic             cnt_en;
   logic             co_unused;

   assign accept  = start && !stop;
   assign at_term = cfg_dir ? (count == {WIDTH{1'b1}}) : (count == '0);

`ifdef TIMER_CTRL_PRESCALE_EN
   logic [PRE_WIDTH-1:0] cfg_pre;
   logic [PRE_WIDTH-1:0] pre_cnt;

   assign step = (pre_cnt == cfg_pre);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cfg_pre <= '0;
         pre_cnt <= '0;
      end else begin
         if (accept)
            cfg_pre <= prescale;
         if (state == LOAD)
            pre_cnt <= '0;
         else if (state == RUN)
            pre_cnt <= step ? '0 : pre_cnt + 1'b1;
      end
   end
`else
   localparam int PRE_WIDTH_UNUSED = PRE_WIDTH;
   assign step = 1'b1;
`endif

   // State register, captured configuration and the registered tick
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         cfg_mode   <= 1'b0;
         cfg_dir    <= 1'b0;
         cfg_reload <= '0;
         tick       <= 1'b0;
      end else begin
         state <= state_nx;
         tick  <= term_hit;
         if (accept) begin
            cfg_mode   <= mode;
            cfg_dir    <= dir;
            cfg_reload <= reload;
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept) state_nx = LOAD;
         LOAD: begin
            if (stop)       state_nx = IDLE;
            else if (start) state_nx = LOAD;
            else            state_nx = RUN;
         end
         RUN: begin
            if (stop)                       state_nx = IDLE;
            else if (start)                 state_nx = LOAD;
            else if (term_hit && !cfg_mode) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // A start or stop in the same cycle overrides any step, reload or tick
   always_comb begin
      run_ok   = (state == RUN) && !stop && !start;
      term_hit = run_ok && step && at_term;
      cnt_en   = run_ok && step && !at_term;
      cnt_load = ((state == LOAD) && !stop && !start) || (term_hit && cfg_mode);
      busy     = (state != IDLE);
   end

   Counter #(.WIDTH(WIDTH)) u_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .in       (cfg_reload),
      .up_down  (cfg_dir),
      .count_en (cnt_en),
      .count    (count),
      .co       (co_unused)
   );

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - directed vector bench for timer_ctrl
// Covers the prescale divider when TIMER_CTRL_PRESCALE_EN is defined.

module tb_timer_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, start, stop, mode, dir;
   logic [7:0] reload;
   logic [3:0] prescale;
   logic [7:0] count;
   logic       busy, tick;
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   timer_ctrl #(.WIDTH(8), .PRE_WIDTH(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .stop     (stop),
      .mode     (mode),
      .dir      (dir),
      .reload   (reload),
`ifdef TIMER_CTRL_PRESCALE_EN
      .prescale (prescale),
`endif
      .count    (count),
      .busy     (busy),
      .tick     (tick)
   );

   typedef struct {
      logic       rst_n, start, stop, mode, dir;
      logic [7:0] reload;
      logic [7:0] e_count;
      logic       e_busy, e_tick;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic s, input logic p, input logic m,
                      input logic d, input logic [7:0] rl,
                      input logic [7:0] ec, input logic eb, input logic et);
      vec_t v;
      v.rst_n = r; v.start = s; v.stop = p; v.mode = m; v.dir = d; v.reload = rl;
      v.e_count = ec; v.e_busy = eb; v.e_tick = et;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic drive(input logic r, input logic s, input logic p, input logic m,
                        input logic d, input logic [7:0] rl);
      rst_n = r; start = s; stop = p; mode = m; dir = d; reload = rl;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [7:0] ec, input logic eb, input logic et);
      check({tag, ".count"}, count, ec);
      check({tag, ".busy"}, {7'd0, busy}, {7'd0, eb});
      check({tag, ".tick"}, {7'd0, tick}, {7'd0, et});
   endtask

   initial begin
      prescale = 4'd0;
      // reset
      add(0,0,0,0,0,8'h00, 8'h00,0,0);
      add(0,1,0,1,1,8'h55, 8'h00,0,0);
      // one-shot down, reload 3
      add(1,1,0,0,0,8'h03, 8'h00,1,0);
      add(1,0,0,1,1,8'hAA, 8'h03,1,0);
      add(1,0,0,0,0,8'h00, 8'h02,1,0);
      add(1,0,0,0,0,8'h00, 8'h01,1,0);
      add(1,0,0,0,0,8'h00, 8'h00,1,0);
      add(1,0,0,0,0,8'h00, 8'h00,0,1);
      add(1,0,0,0,0,8'h00, 8'h00,0,0);
      add(1,0,1,0,0,8'h00, 8'h00,0,0);
      // periodic up, reload FC
      add(1,1,0,1,1,8'hFC, 8'h00,1,0);
      add(1,0,0,0,0,8'h00, 8'hFC,1,0);
      add(1,0,0,0,0,8'h00, 8'hFD,1,0);
      add(1,0,0,0,0,8'h00, 8'hFE,1,0);
      add(1,0,0,0,0,8'h00, 8'hFF,1,0);
      add(1,0,0,0,0,8'h00, 8'hFC,1,1);
      add(1,0,0,0,0,8'h00, 8'hFD,1,0);
      add(1,0,0,0,0,8'h00, 8'hFE,1,0);
      add(1,0,0,0,0,8'h00, 8'hFF,1,0);
      add(1,0,0,0,0,8'h00, 8'hFC,1,1);
      add(1,0,0,0,0,8'h00, 8'hFD,1,0);
      // start and stop together: stop wins
      add(1,1,1,0,0,8'h07, 8'hFD,0,0);
      add(1,0,0,0,0,8'h00, 8'hFD,0,0);
      add(1,1,0,0,0,8'h07, 8'hFD,1,0);
      add(1,0,0,0,0,8'h00, 8'h07,1,0);
      add(1,0,0,0,0,8'h00, 8'h06,1,0);
      add(1,0,1,0,0,8'h00, 8'h06,0,0);
      // periodic down, reload 0: period 1, tick every cycle
      add(1,1,0,1,0,8'h00, 8'h06,1,0);
      add(1,0,0,0,0,8'h00, 8'h00,1,0);
      add(1,0,0,0,0,8'h00, 8'h00,1,1);
      add(1,0,0,0,0,8'h00, 8'h00,1,1);
      add(1,0,1,0,0,8'h00, 8'h00,0,0);
      // one-shot up, reload FE: terminal at FF
      add(1,1,0,0,1,8'hFE, 8'h00,1,0);
      add(1,0,0,0,0,8'h00, 8'hFE,1,0);
      add(1,0,0,0,0,8'h00, 8'hFF,1,0);
      add(1,0,0,0,0,8'h00, 8'hFF,0,1);
      add(1,0,0,0,0,8'h00, 8'hFF,0,0);

      rst_n = 0; start = 0; stop = 0; mode = 0; dir = 0; reload = 0;
      @(negedge clk);
      foreach (vecs[i]) begin
         drive(vecs[i].rst_n, vecs[i].start, vecs[i].stop, vecs[i].mode, vecs[i].dir, vecs[i].reload);
         expect_out($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_busy, vecs[i].e_tick);
      end

      // restart at terminal count: no tick, new reload after LOAD
      drive(1,1,0,0,0,8'h02); expect_out("rs_load", 8'hFF,1,0);
      drive(1,0,0,0,0,8'h00); expect_out("rs_2", 8'h02,1,0);
      drive(1,0,0,0,0,8'h00); expect_out("rs_1", 8'h01,1,0);
      drive(1,0,0,0,0,8'h00); expect_out("rs_0", 8'h00,1,0);
      drive(1,1,0,0,0,8'h09); expect_out("rs_restart", 8'h00,1,0);
      drive(1,0,0,0,0,8'h00); expect_out("rs_9", 8'h09,1,0);
      drive(1,0,0,0,0,8'h00); expect_out("rs_8", 8'h08,1,0);

      // reset mid-run
      drive(1,1,0,0,0,8'h05); expect_out("rm_load", 8'h08,1,0);
      drive(1,0,0,0,0,8'h00); expect_out("rm_5", 8'h05,1,0);
      drive(1,0,0,0,0,8'h00); expect_out("rm_4", 8'h04,1,0);
      drive(0,0,0,0,0,8'h00); expect_out("rm_rst", 8'h00,0,0);
      drive(1,0,0,0,0,8'h00); expect_out("rm_idle", 8'h00,0,0);

`ifdef TIMER_CTRL_PRESCALE_EN
      // prescale 2: one step every 3 clocks
      prescale = 4'd2;
      drive(1,1,0,0,0,8'h01); expect_out("ps_load", 8'h00,1,0);
      prescale = 4'd0;
      for (int k = 0; k < 3; k++) begin
         drive(1,0,0,0,0,8'h00); expect_out($sformatf("ps_1_%0d", k), 8'h01,1,0);
      end
      for (int k = 0; k < 3; k++) begin
         drive(1,0,0,0,0,8'h00); expect_out($sformatf("ps_0_%0d", k), 8'h00,1,0);
      end
      drive(1,0,0,0,0,8'h00); expect_out("ps_tick", 8'h00,0,1);
      drive(1,0,0,0,0,8'h00); expect_out("ps_idle", 8'h00,0,0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
